// File: rtl/layer_output_serializer.sv
// Collects one-cycle neuron results into a holding register, then replays them
// one word per cycle (neuron 0 first) as the input stream of the next layer.
module layer_output_serializer #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16,
  parameter int cntWidth  = (numNeuron > 1) ? $clog2(numNeuron) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*dataWidth-1:0] neuronOut,
  input  logic [numNeuron-1:0]           neuronValid,
  output logic [dataWidth-1:0]           dataOut,
  output logic                           dataValid,
  output logic                           layerDone,
  output logic                           busy,
  output logic                           overrun
);

  typedef enum logic {COLLECT, SHIFT} state_t;

  localparam logic [cntWidth-1:0] LAST_IDX = cntWidth'(numNeuron - 1);

  state_t                 state_reg, state_next;
  logic [numNeuron-1:0]   seen_reg;
  logic [cntWidth-1:0]    index_reg;
  logic [dataWidth-1:0]   hold_reg [numNeuron];
  logic [dataWidth-1:0]   data_out_reg;
  logic                   data_valid_reg;
  logic                   layer_done_reg;
  logic                   busy_reg;
  logic                   overrun_reg;

  logic [numNeuron-1:0]   capture;
  logic                   start_stream;
  logic                   last_word;
  logic                   violation;
  logic [cntWidth-1:0]    index_next;
  logic [dataWidth-1:0]   first_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= COLLECT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    capture      = '0;
    start_stream = 1'b0;
    last_word    = 1'b0;
    violation    = 1'b0;
    case (state_reg)
      COLLECT: begin
        capture   = neuronValid;
        violation = |(neuronValid & seen_reg);
        if (&(seen_reg | neuronValid)) begin
          start_stream = 1'b1;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        // Reports arriving while streaming are dropped and flagged.
        violation = |neuronValid;
        if (index_reg == LAST_IDX) begin
          last_word  = 1'b1;
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  assign index_next = index_reg + 1'b1;
  // Neuron 0 may report on the completing edge, so bypass the holding register.
  assign first_word = neuronValid[0] ? neuronOut[dataWidth-1:0] : hold_reg[0];

  always_ff @(posedge clk) begin
    for (int i = 0; i < numNeuron; i++) begin
      if (capture[i]) hold_reg[i] <= neuronOut[i*dataWidth +: dataWidth];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_reg       <= '0;
      index_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      layer_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (violation) overrun_reg <= 1'b1;
      if (start_stream) begin
        seen_reg       <= '0;
        index_reg      <= '0;
        data_out_reg   <= first_word;
        data_valid_reg <= 1'b1;
        busy_reg       <= 1'b1;
        layer_done_reg <= (numNeuron == 1);
      end else if (state_reg == COLLECT) begin
        seen_reg <= seen_reg | neuronValid;
      end else if (last_word) begin
        data_valid_reg <= 1'b0;
        busy_reg       <= 1'b0;
        layer_done_reg <= 1'b0;
      end else begin
        index_reg      <= index_next;
        data_out_reg   <= hold_reg[index_next];
        layer_done_reg <= (index_next == LAST_IDX);
      end
    end
  end

  assign dataOut   = data_out_reg;
  assign dataValid = data_valid_reg;
  assign layerDone = layer_done_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: a 4-neuron instance checked cycle by cycle
// against a word-queue model, plus a 1-neuron instance for single-word streams.
module tb_layer_output_serializer;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] neuron_out;
  logic [N-1:0]    neuron_valid;
  logic [DW-1:0]   data_out;
  logic            data_valid, layer_done, busy, overrun;

  logic            rst1;
  logic [DW-1:0]   neuron_out1;
  logic            neuron_valid1;
  logic [DW-1:0]   data_out1;
  logic            data_valid1, layer_done1, busy1, overrun1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  layer_output_serializer #(.numNeuron(N), .dataWidth(DW)) dut4 (
    .clk(clk), .rst(rst), .neuronOut(neuron_out), .neuronValid(neuron_valid),
    .dataOut(data_out), .dataValid(data_valid), .layerDone(layer_done),
    .busy(busy), .overrun(overrun)
  );

  layer_output_serializer #(.numNeuron(1), .dataWidth(DW)) dut1 (
    .clk(clk), .rst(rst1), .neuronOut(neuron_out1), .neuronValid(neuron_valid1),
    .dataOut(data_out1), .dataValid(data_valid1), .layerDone(layer_done1),
    .busy(busy1), .overrun(overrun1)
  );

  // Reference model: words still owed to the stream are kept in a queue.
  logic [DW-1:0] m_hold [N];
  logic [N-1:0]  m_seen;
  logic [DW-1:0] m_q [$];
  logic          m_in_shift, m_done, m_overrun;
  logic [DW-1:0] m_data;

  function void model_reset();
    m_seen = '0; m_q.delete(); m_in_shift = 0; m_done = 0; m_overrun = 0; m_data = '0;
  endfunction

  function void model_edge(input logic [N-1:0] v, input logic [N*DW-1:0] d);
    if (m_in_shift) begin
      if (v != '0) m_overrun = 1;
      if (m_q.size() > 0) begin
        m_data = m_q.pop_front();
        m_done = (m_q.size() == 0);
      end else begin
        m_in_shift = 0;
        m_done     = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          if (m_seen[i]) m_overrun = 1;
          m_hold[i] = d[i*DW +: DW];
          m_seen[i] = 1'b1;
        end
      end
      if (&m_seen) begin
        for (int i = 0; i < N; i++) m_q.push_back(m_hold[i]);
        m_seen     = '0;
        m_data     = m_q.pop_front();
        m_in_shift = 1;
        m_done     = (m_q.size() == 0);
      end
    end
  endfunction

  function logic [DW+3:0] exp_vec();
    return {m_in_shift, m_done, m_in_shift, m_overrun, m_data};
  endfunction

  function logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  // Drive one cycle of inputs from a negedge; returns at the following negedge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d);
    neuron_valid = v;
    neuron_out   = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    neuron_valid = '0;
    neuron_out   = rand_data();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({data_valid, layer_done, busy, overrun, data_out} !== '0) begin
      errors++;
      $display("FAIL reset4: got %h want 0", {data_valid, layer_done, busy, overrun, data_out});
    end
    checks++;
    if ({data_valid1, layer_done1, busy1, overrun1, data_out1} !== '0) begin
      errors++;
      $display("FAIL reset1: got %h want 0", {data_valid1, layer_done1, busy1, overrun1, data_out1});
    end
    rst = 1'b0; rst1 = 1'b0;
    model_reset();
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] got [$];
    int done_cnt = 0;
    cycle(4'b0000, rand_data());
    for (int c = 0; c < 7; c++) begin
      if (c == 0) cycle(4'b1111, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
      else        cycle(4'b0000, rand_data());
      if (data_valid) got.push_back(data_out);
      if (layer_done) done_cnt++;
      checks++;
      if ({data_valid, layer_done, busy, overrun, data_out} !== exp_vec()) begin
        errors++;
        $display("FAIL simultaneous c%0d: got %h want %h", c,
                 {data_valid, layer_done, busy, overrun, data_out}, exp_vec());
      end
    end
    checks++;
    if (got.size() != 4 || done_cnt != 1 || got[0] !== 16'h1 || got[1] !== 16'h2 ||
        got[2] !== 16'h3 || got[3] !== 16'h4) begin
      errors++;
      $display("FAIL simultaneous_stream: got %0d words %0d done, want 1,2,3,4 and 1 done",
               got.size(), done_cnt);
    end
  endtask

  task automatic test_staggered();
    logic [N-1:0] v_seq [14] = '{4'b0100, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [DW-1:0] got [$];
    int first_valid = -1;
    for (int c = 0; c < 14; c++) begin
      cycle(v_seq[c], {16'h000C, 16'h000A, 16'h000D, 16'h000B});
      if (data_valid) begin
        got.push_back(data_out);
        if (first_valid < 0) first_valid = c;
      end
      checks++;
      if ({data_valid, layer_done, busy, overrun, data_out} !== exp_vec()) begin
        errors++;
        $display("FAIL staggered c%0d: got %h want %h", c,
                 {data_valid, layer_done, busy, overrun, data_out}, exp_vec());
      end
    end
    checks++;
    if (first_valid != 7 || got.size() != 4 || got[0] !== 16'hB || got[1] !== 16'hD ||
        got[2] !== 16'hA || got[3] !== 16'hC) begin
      errors++;
      $display("FAIL staggered_stream: got first valid c%0d, %0d words; want c7, B D A C",
               first_valid, got.size());
    end
  endtask

  task automatic test_double_report();
    logic [N-1:0] v_seq [10] = '{4'b0010, 4'b0010, 4'b0001, 4'b1100, 4'b0000,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [N*DW-1:0] d;
    int idx = 0;
    logic [DW-1:0] elem1 = '0;
    for (int c = 0; c < 10; c++) begin
      d = rand_data();
      if (c == 0) d[DW +: DW] = 16'h1111;
      if (c == 1) d[DW +: DW] = 16'h2222;
      cycle(v_seq[c], d);
      if (data_valid) begin
        if (idx == 1) elem1 = data_out;
        idx++;
      end
      checks++;
      if ({data_valid, layer_done, busy, overrun, data_out} !== exp_vec()) begin
        errors++;
        $display("FAIL double_report c%0d: got %h want %h", c,
                 {data_valid, layer_done, busy, overrun, data_out}, exp_vec());
      end
    end
    checks++;
    if (elem1 !== 16'h2222 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL double_report_final: got elem1 %h overrun %b want 2222 1", elem1, overrun);
    end
  endtask

  task automatic test_report_during_shift();
    logic [N-1:0] v_seq [16] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b1000,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [N*DW-1:0] d;
    int early_valid = 0;
    for (int c = 0; c < 16; c++) begin
      d = rand_data();
      if (c == 1) d[DW-1:0] = 16'hFFFF;
      cycle(v_seq[c], d);
      if (c >= 5 && c <= 10 && data_valid) early_valid++;
      checks++;
      if ({data_valid, layer_done, busy, overrun, data_out} !== exp_vec()) begin
        errors++;
        $display("FAIL shift_report c%0d: got %h want %h", c,
                 {data_valid, layer_done, busy, overrun, data_out}, exp_vec());
      end
    end
    checks++;
    if (early_valid != 0) begin
      errors++;
      $display("FAIL partial_collect: got %0d valid cycles want 0", early_valid);
    end
  endtask

  task automatic test_async_reset();
    cycle(4'b1111, rand_data());
    cycle(4'b0000, rand_data());
    cycle(4'b0000, rand_data());
    checks++;
    if (data_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got %b want 1", data_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({data_valid, busy, layer_done, overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b want 0000", {data_valid, busy, layer_done, overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 12; c++) begin
      cycle((c < 4) ? N'(1 << (3 - c)) : 4'b0000, rand_data());
      checks++;
      if ({data_valid, layer_done, busy, overrun, data_out} !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset c%0d: got %h want %h", c,
                 {data_valid, layer_done, busy, overrun, data_out}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 5) == 0);
      cycle(v, rand_data());
      checks++;
      if ({data_valid, layer_done, busy, overrun, data_out} !== exp_vec()) begin
        errors++;
        $display("FAIL random c%0d: got %h want %h", c,
                 {data_valid, layer_done, busy, overrun, data_out}, exp_vec());
      end
    end
  endtask

  task automatic test_single();
    logic          v_seq [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [DW-1:0] d_seq [6] = '{16'h1234, 16'h7FFF, 16'h5555, 16'h8000, 16'h0F0F, 16'h0000};
    logic          e_v   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [DW-1:0] e_d   [6] = '{16'h0000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000};
    for (int c = 0; c < 6; c++) begin
      neuron_valid1 = v_seq[c];
      neuron_out1   = d_seq[c];
      @(negedge clk);
      checks++;
      if ({data_valid1, layer_done1, busy1, overrun1, data_out1} !==
          {e_v[c], e_v[c], e_v[c], 1'b0, e_d[c]}) begin
        errors++;
        $display("FAIL single c%0d: got %h want %h", c,
                 {data_valid1, layer_done1, busy1, overrun1, data_out1},
                 {e_v[c], e_v[c], e_v[c], 1'b0, e_d[c]});
      end
    end
    neuron_valid1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    neuron_valid = '0; neuron_out = '0;
    neuron_valid1 = 1'b0; neuron_out1 = '0;
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_staggered();
    test_double_report();
    test_report_during_shift();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
